// File: rtl/ntt_ct_butterfly_module_pkg.sv
// Shared constants and types for the inverse-NTT Cooley-Tukey butterfly.
// q = 12289, Montgomery radix R = 2^18. Optional build macro: NTT_CT_CANON_EN.
package ntt_ct_butterfly_module_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned R_LOG   = 18;
    localparam int unsigned RED_LAT = 4;

    typedef logic [DATA_W-1:0]   coef_t;
    typedef logic [2*DATA_W-1:0] prod_t;

    localparam coef_t Q        = 16'd12289;
    localparam coef_t Q2       = 16'd24578;
    localparam coef_t MONT_ONE = 16'd4075;

    // -q^-1 mod 2^18 (q = 3*2^12 + 1, so q * (3*2^12 - 1) = -1 mod 2^18)
    localparam logic [R_LOG-1:0] QINV_NEG = 18'd12287;

`ifdef NTT_CT_CANON_EN
    localparam int unsigned LATENCY = RED_LAT + 4;
`else
    localparam int unsigned LATENCY = RED_LAT + 3;
`endif

    // Bring a value below 4q into [0, q): subtract 2q, then q, conditionally.
    function automatic coef_t canon_reduce(input coef_t x);
        coef_t y;
        y = (x >= Q2) ? coef_t'(x - Q2) : x;
        y = (y >= Q)  ? coef_t'(y - Q)  : y;
        return y;
    endfunction

endpackage

// File: rtl/ntt_ct_butterfly_module_if.sv
// Operand/result bus of one butterfly lane, driven by the inverse-NTT control FSM.
interface ntt_ct_butterfly_module_if;
    import ntt_ct_butterfly_module_pkg::*;

    logic  load;
    logic  en;
    coef_t a;
    coef_t b;
    coef_t omega;
    coef_t a_out;
    coef_t b_out;
    logic  valid;

    modport master (
        output load, en, a, b, omega,
        input  a_out, b_out, valid
    );

    modport slave (
        input  load, en, a, b, omega,
        output a_out, b_out, valid
    );

endinterface

// File: rtl/ntt_ct_butterfly_module_mont.sv
// Pipelined Montgomery reduction, R = 2^18, q = 12289: out = in * R^-1 mod q, out in [0, 2q).
// Latency RED_LAT = 4 edges from the edge that samples load to valid; stalls on en = 0.
module montgomery_reduction
    import ntt_ct_butterfly_module_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    input  logic        reset,
    input  logic [31:0] in,
    output logic [15:0] out,
    output logic        valid
);

    logic [31:0]        p1_q;
    logic [R_LOG-1:0]   m1_q;
    logic [33:0]        s2_q;
    logic [15:0]        u3_q;
    logic [15:0]        out_q;
    logic [RED_LAT-1:0] v_q;

    logic [R_LOG-1:0]   m_d;
    logic [33:0]        s_d;

    // m = in * (-q^-1) mod R; sum = in + m*q is an exact multiple of R
    always_comb begin
        m_d = in[R_LOG-1:0] * QINV_NEG;
        s_d = {2'b00, p1_q} + ({16'b0, m1_q} * {18'b0, Q});
    end

    // Data pipeline; the final conditional subtract keeps the result below 2q for any 32-bit input
    always_ff @(posedge clk) begin
        if (en) begin
            p1_q  <= in;
            m1_q  <= m_d;
            s2_q  <= s_d;
            u3_q  <= s2_q[33:18];
            out_q <= (u3_q >= Q2) ? 16'(u3_q - Q) : u3_q;
        end
    end

    // Valid shift register tracking the data pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else if (en) begin
            v_q <= {v_q[RED_LAT-2:0], load};
        end
    end

    assign out   = out_q;
    assign valid = v_q[RED_LAT-1];

endmodule

// File: rtl/ntt_ct_butterfly_module.sv
// Cooley-Tukey butterfly for the inverse NTT: t = red(W*b), a_out = a + t, b_out = a + 2q - t.
// One butterfly per cycle, globally stalled by en. Latency RED_LAT+3 en-cycles, counting the
// capture edge as the first. Build macro NTT_CT_CANON_EN adds a stage reducing outputs to [0, q).
module ntt_ct_butterfly_module
    import ntt_ct_butterfly_module_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    ntt_ct_butterfly_module_if.slave   bus
);

    // index of the load flag aligned with the reducer output stage
    localparam int unsigned LD_LAST = RED_LAT + 1;

    coef_t          a_s0_q, b_s0_q, w_s0_q;
    prod_t          p_q;
    prod_t          p_d;
    coef_t          a_dly_q [RED_LAT+1];
    logic [LD_LAST:0] ld_q;
    coef_t          t;
    logic           red_valid;
    logic           red_valid_q;
    coef_t          sum_a_d, sum_b_d;
    coef_t          sum_a_q, sum_b_q;
    logic           sum_vld_q;

    // S0: operand capture
    always_ff @(posedge clk) begin
        if (bus.en) begin
            a_s0_q <= bus.a;
            b_s0_q <= bus.b;
            w_s0_q <= bus.omega;
        end
    end

    // S1: single registered 16x16 product (maps onto one DSP with its M register)
    always_comb begin
        p_d = {16'b0, b_s0_q} * {16'b0, w_s0_q};
    end

    always_ff @(posedge clk) begin
        if (bus.en) begin
            p_q <= p_d;
        end
    end

    // Load flag shift register S0..S(1+RED_LAT); it alone drives the output valid
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_q <= '0;
        end else if (bus.en) begin
            ld_q <= {ld_q[LD_LAST-1:0], bus.load};
        end
    end

    // Delay line carrying a alongside the multiply and reduction stages
    always_ff @(posedge clk) begin
        if (bus.en) begin
            a_dly_q[0] <= a_s0_q;
            for (int unsigned i = 1; i <= RED_LAT; i++) begin
                a_dly_q[i] <= a_dly_q[i-1];
            end
        end
    end

    montgomery_reduction u_red (
        .clk   (clk),
        .load  (ld_q[1]),
        .en    (bus.en),
        .reset (reset),
        .in    (p_q),
        .out   (t),
        .valid (red_valid)
    );

    // Sum/difference; a < 2q and t < 2q so neither wraps 16 bits
    always_comb begin
        sum_a_d = a_dly_q[RED_LAT] + t;
        sum_b_d = a_dly_q[RED_LAT] + Q2 - t;
    end

    // S(2+RED_LAT): output registers, updated only for real operands so bubbles hold them
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_vld_q <= 1'b0;
            sum_a_q   <= '0;
            sum_b_q   <= '0;
        end else if (bus.en) begin
            sum_vld_q <= ld_q[LD_LAST];
            if (ld_q[LD_LAST]) begin
                sum_a_q <= sum_a_d;
                sum_b_q <= sum_b_d;
            end
        end
    end

    // Reducer valid delayed one stage, used only to cross-check the local valid chain
    always_ff @(posedge clk) begin
        if (reset) begin
            red_valid_q <= 1'b0;
        end else if (bus.en) begin
            red_valid_q <= red_valid;
        end
    end

    a_valid_align: assert property (@(posedge clk) disable iff (reset) sum_vld_q == red_valid_q);

`ifdef NTT_CT_CANON_EN
    coef_t can_a_q, can_b_q;
    logic  can_vld_q;

    // Extra stage: reduce both results from [0, 4q) to canonical [0, q)
    always_ff @(posedge clk) begin
        if (reset) begin
            can_vld_q <= 1'b0;
            can_a_q   <= '0;
            can_b_q   <= '0;
        end else if (bus.en) begin
            can_vld_q <= sum_vld_q;
            if (sum_vld_q) begin
                can_a_q <= canon_reduce(sum_a_q);
                can_b_q <= canon_reduce(sum_b_q);
            end
        end
    end

    assign bus.a_out = can_a_q;
    assign bus.b_out = can_b_q;
    assign bus.valid = can_vld_q;
`else
    assign bus.a_out = sum_a_q;
    assign bus.b_out = sum_b_q;
    assign bus.valid = sum_vld_q;
`endif

endmodule

// File: tb/tb_ntt_ct_butterfly_module.sv
// Self-checking bench for ntt_ct_butterfly_module; reference model is plain modular arithmetic.
// Honors NTT_CT_CANON_EN (latency 8, exact canonical compare) when defined.
module tb_ntt_ct_butterfly_module;

    localparam int unsigned MQ = 12289;
    localparam longint      RR = 262144;
`ifdef NTT_CT_CANON_EN
    localparam int unsigned LAT   = 8;
    localparam bit          CANON = 1'b1;
`else
    localparam int unsigned LAT   = 7;
    localparam bit          CANON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ntt_ct_butterfly_module_if bus ();

    ntt_ct_butterfly_module dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned w;
        int unsigned stamp;
    } op_t;

    op_t         pend[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned rinv;
    int unsigned en_edges = 0;

    // ---------------- reference model ----------------
    function automatic int unsigned ref_t(input int unsigned b, input int unsigned w);
        longint x;
        x = (longint'(b) * longint'(w)) % MQ;
        return int'((x * rinv) % MQ);
    endfunction

    function automatic int unsigned ref_a(input op_t o);
        return ((o.a % MQ) + ref_t(o.b, o.w)) % MQ;
    endfunction

    function automatic int unsigned ref_b(input op_t o);
        return ((o.a % MQ) + MQ - ref_t(o.b, o.w)) % MQ;
    endfunction

    function automatic int unsigned norm(input int unsigned x);
        return CANON ? x : x % MQ;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (bus.en) en_edges++;
        #1;
    endtask

    task automatic drive(input logic ld, input logic e, input int unsigned a,
                         input int unsigned b, input int unsigned w);
        op_t o;
        bus.load  = ld;
        bus.en    = e;
        bus.a     = 16'(a);
        bus.b     = 16'(b);
        bus.omega = 16'(w);
        if (ld && e && !reset) begin
            o.a = a; o.b = b; o.w = w; o.stamp = en_edges + 1;
            pend.push_back(o);
        end
    endtask

    // single load, then wait (bounded) for its valid pulse
    task automatic fire(input int unsigned a, input int unsigned b, input int unsigned w,
                        output int unsigned lat, output int unsigned oa, output int unsigned ob);
        drive(1'b1, 1'b1, a, b, w);
        tick();
        lat = 1;
        drive(1'b0, 1'b1, 0, 0, 0);
        while (bus.valid !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        oa = bus.a_out;
        ob = bus.b_out;
        if (pend.size() > 0) void'(pend.pop_front());
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 5, 7, 4075);
        tick();
        tick();
        n_tests++;
        if (bus.valid !== 1'b0 || bus.a_out !== 16'd0 || bus.b_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b a_out=%0d b_out=%0d, want 0/0/0",
                     bus.valid, bus.a_out, bus.b_out);
        end
        reset = 1'b0;
        drive(1'b0, 1'b1, 0, 0, 0);
        for (int i = 0; i < LAT + 2; i++) tick();
        n_tests++;
        if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load_dropped: valid=%b, want 0", bus.valid);
        end
    endtask

    task automatic test_basic();
        int unsigned lat, oa, ob;
        fire(5, 7, 4075, lat, oa, ob);
        n_tests++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, want %0d", lat, LAT);
        end
        n_tests++;
        if (norm(oa) != 12 || oa >= 4 * MQ) begin
            n_fail++;
            $display("FAIL basic_a_out: got %0d, want 12 (mod q)", oa);
        end
        n_tests++;
        if (norm(ob) != 12287 || ob >= 4 * MQ) begin
            n_fail++;
            $display("FAIL basic_b_out: got %0d, want 12287 (mod q)", ob);
        end
        tick();
        tick();
        n_tests++;
        if (bus.valid !== 1'b0 || bus.a_out !== 16'(oa) || bus.b_out !== 16'(ob)) begin
            n_fail++;
            $display("FAIL bubble_hold: valid=%b a_out=%0d b_out=%0d, want 0/%0d/%0d",
                     bus.valid, bus.a_out, bus.b_out, oa, ob);
        end
    endtask

    task automatic test_zero_twiddle();
        int unsigned lat, oa, ob;
        fire(100, 24577, 0, lat, oa, ob);
        n_tests++;
        if (norm(oa) != 100 || norm(ob) != 100 || lat != LAT) begin
            n_fail++;
            $display("FAIL zero_twiddle: a_out=%0d b_out=%0d lat=%0d, want 100/100 lat %0d",
                     oa, ob, lat, LAT);
        end
    endtask

    task automatic test_max_operands();
        int unsigned lat, oa, ob;
        op_t o;
        o.a = 24577; o.b = 24577; o.w = 12288; o.stamp = 0;
        fire(o.a, o.b, o.w, lat, oa, ob);
        n_tests++;
        if (norm(oa) != ref_a(o) || norm(ob) != ref_b(o)) begin
            n_fail++;
            $display("FAIL max_operands: a_out=%0d b_out=%0d, want %0d/%0d (mod q)",
                     oa, ob, ref_a(o), ref_b(o));
        end
        n_tests++;
        if (oa >= 49156 || ob >= 49156 || (!CANON && ob == 0)) begin
            n_fail++;
            $display("FAIL max_range: a_out=%0d b_out=%0d, want raw values in range", oa, ob);
        end
    endtask

    task automatic run_burst(input int unsigned n, input int unsigned stall_pct, input string tag);
        int unsigned sent, got, budget;
        logic        e_now;
        logic [15:0] pa, pb;
        logic        pv;
        op_t         o;
        sent = 0; got = 0; budget = 0;
        pa = bus.a_out; pb = bus.b_out; pv = bus.valid;
        while ((sent < n || pend.size() != 0) && budget < n * 4 + 60) begin
            e_now = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            if (sent < n) begin
                drive(1'b1, e_now, $urandom_range(2 * MQ - 1), $urandom_range(2 * MQ - 1),
                      $urandom_range(MQ - 1));
                if (e_now) sent++;
            end else begin
                drive(1'b0, e_now, 0, 0, 0);
            end
            tick();
            budget++;
            if (!e_now) begin
                n_tests++;
                if (bus.valid !== pv || bus.a_out !== pa || bus.b_out !== pb) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: valid=%b a=%0d b=%0d, want %b/%0d/%0d",
                             tag, bus.valid, bus.a_out, bus.b_out, pv, pa, pb);
                end
            end else if (bus.valid === 1'b1) begin
                got++;
                n_tests++;
                if (pend.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_spurious_valid: got valid, want none pending", tag);
                end else begin
                    o = pend.pop_front();
                    if (norm(bus.a_out) != ref_a(o) || norm(bus.b_out) != ref_b(o) ||
                        bus.a_out >= 16'(4 * MQ) || bus.b_out >= 16'(4 * MQ)) begin
                        n_fail++;
                        $display("FAIL %s_data: a_out=%0d b_out=%0d, want %0d/%0d (mod q)",
                                 tag, bus.a_out, bus.b_out, ref_a(o), ref_b(o));
                    end
                    n_tests++;
                    if (en_edges != o.stamp + LAT - 1) begin
                        n_fail++;
                        $display("FAIL %s_latency: got %0d en-cycles, want %0d",
                                 tag, en_edges - o.stamp + 1, LAT);
                    end
                end
            end
            pa = bus.a_out; pb = bus.b_out; pv = bus.valid;
        end
        n_tests++;
        if (got != n || pend.size() != 0) begin
            n_fail++;
            $display("FAIL %s_count: got %0d valids, want %0d", tag, got, n);
        end
        pend.delete();
        drive(1'b0, 1'b1, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_burst(64, 0, "b2b");
    endtask

    task automatic test_stall();
        run_burst(48, 35, "stall");
    endtask

    task automatic test_reset_mid();
        int unsigned lat, oa, ob, bad;
        op_t o;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, $urandom_range(2 * MQ - 1), $urandom_range(2 * MQ - 1),
                  $urandom_range(MQ - 1));
            tick();
        end
        drive(1'b0, 1'b1, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.valid !== 1'b0) bad++;
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.valid !== 1'b0 || bus.a_out !== 16'd0 || bus.b_out !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: valid=%b a_out=%0d b_out=%0d, want 0/0/0",
                     bus.valid, bus.a_out, bus.b_out);
        end
        tick();
        reset = 1'b0;
        pend.delete();
        for (int i = 0; i < LAT + 6; i++) begin
            tick();
            if (bus.valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_no_valid: got %0d valid cycles, want 0", bad);
        end
        o.a = $urandom_range(2 * MQ - 1); o.b = $urandom_range(2 * MQ - 1);
        o.w = $urandom_range(MQ - 1);     o.stamp = 0;
        fire(o.a, o.b, o.w, lat, oa, ob);
        n_tests++;
        if (lat != LAT || norm(oa) != ref_a(o) || norm(ob) != ref_b(o)) begin
            n_fail++;
            $display("FAIL midreset_recover: lat=%0d a_out=%0d b_out=%0d, want %0d/%0d/%0d",
                     lat, oa, ob, LAT, ref_a(o), ref_b(o));
        end
    endtask

    initial begin
        longint rmod;
        rmod = RR % MQ;
        rinv = 0;
        for (int unsigned x = 1; x < MQ; x++) begin
            if ((longint'(x) * rmod) % MQ == 1) rinv = x;
        end
        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.en    = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
        bus.omega = '0;
        test_reset();
        test_basic();
        test_zero_twiddle();
        test_max_operands();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
